// File: rtl/ethernet_rx_l2_decoder_pkg.sv
// Shared RX layer-2 bus types, ethertype constants and decoder state encoding.
package ethernet_rx_l2_decoder_pkg;

  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
  localparam logic [15:0] ETHERTYPE_MIN  = 16'h0600;

  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        drop;
  } EthernetRxBus;

  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        drop;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        has_vlan;
    logic [11:0] vlan_id;
    logic [2:0]  vlan_pcp;
  } EthernetRxL2Bus;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        has_vlan;
    logic [11:0] vlan_id;
    logic [2:0]  vlan_pcp;
  } l2_hdr_t;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_0, S_HDR_1, S_HDR_2, S_HDR_3, S_HDR_VLAN, S_BODY, S_FLUSH, S_DISCARD
  } l2_state_e;

  // Keeps the leading n bytes of a big-endian word, zeroes the rest.
  function automatic logic [31:0] byte_mask(input logic [2:0] n);
    case (n)
      3'd0:    byte_mask = 32'h0000_0000;
      3'd1:    byte_mask = 32'hFF00_0000;
      3'd2:    byte_mask = 32'hFFFF_0000;
      3'd3:    byte_mask = 32'hFFFF_FF00;
      default: byte_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/ethernet_payload_realigner.sv
// Packs a byte stream of partial words into full left-justified 32-bit words,
// keeping up to three leftover bytes in a carry register.
module ethernet_payload_realigner
  import ethernet_rx_l2_decoder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [2:0]  n_i,
  input  logic [31:0] data_i,
  input  logic        flush_i,
  output logic [31:0] word_o,
  output logic [2:0]  bytes_valid_o,
  output logic        valid_o,
  output logic [1:0]  count_o
);

  logic [23:0] carry_q, carry_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  bv_q, bv_d;
  logic        vld_q, vld_d;
  logic [55:0] cat;
  logic [2:0]  t;

  always_comb begin
    // Input bytes land directly behind the c carried bytes.
    cat     = {carry_q, 32'h0} | ({data_i & byte_mask(n_i), 24'h0} >> {cnt_q, 3'b000});
    t       = {1'b0, cnt_q} + n_i;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    word_d  = '0;
    bv_d    = '0;
    vld_d   = 1'b0;
    if (clear_i) begin
      carry_d = '0;
      cnt_d   = '0;
    end else if (flush_i) begin
      word_d  = {carry_q, 8'h00};
      bv_d    = {1'b0, cnt_q};
      vld_d   = (cnt_q != 2'd0);
      carry_d = '0;
      cnt_d   = '0;
    end else if (valid_i) begin
      cnt_d = t[1:0];
      if (t[2]) begin
        word_d  = cat[55:24];
        bv_d    = 3'd4;
        vld_d   = 1'b1;
        carry_d = cat[23:0];
      end else begin
        carry_d = cat[55:32];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      carry_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      bv_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      bv_q    <= bv_d;
      vld_q   <= vld_d;
    end
  end

  assign word_o        = word_q;
  assign bytes_valid_o = bv_q;
  assign valid_o       = vld_q;
  assign count_o       = cnt_q;

endmodule

// File: rtl/ethernet_rx_l2_decoder.sv
// L2 receive decoder: parses MAC/VLAN/ethertype header, filters on destination
// and emits the payload realigned to 32-bit words with header fields attached.
module ethernet_rx_l2_decoder
  import ethernet_rx_l2_decoder_pkg::*;
#(
  parameter bit VLAN_ENABLE     = 1'b1,
  parameter bit ALLOW_MULTICAST = 1'b1
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  input  EthernetRxBus   rx_bus,
  input  logic [47:0]    our_mac_address,
  input  logic           promisc_mode,
  output EthernetRxL2Bus l2_bus,
  output logic [63:0]    perf_rx_l2_accepted,
  output logic [63:0]    perf_rx_l2_drop_filter,
  output logic [63:0]    perf_rx_l2_drop_runt
);

  l2_state_e   state_q, state_d, cur;
  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic        hv_q, hv_d;
  logic [11:0] vid_q, vid_d;
  logic [2:0]  pcp_q, pcp_d;
  l2_hdr_t     hdr_q, hdr_d;
  logic        start_q, start_d, commit_q, commit_d, drop_q, drop_d;
  logic [63:0] acc_q, filt_q, runt_q;
  logic        acc_inc, filt_inc, runt_inc;
  logic        rl_clear, rl_valid, rl_flush, rl_vld;
  logic [2:0]  rl_n, rl_bv;
  logic [31:0] rl_data, rl_word;
  logic [1:0]  rl_cnt;
  logic        parse_et, hdr_abort, addr_ok;
  logic [15:0] et;

  assign et      = rx_bus.data[31:16];
  assign addr_ok = promisc_mode || (dst_q == our_mac_address) || (&dst_q) ||
                   (ALLOW_MULTICAST && dst_q[40]);

  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    src_d    = src_q;
    hv_d     = hv_q;
    vid_d    = vid_q;
    pcp_d    = pcp_q;
    hdr_d    = hdr_q;
    start_d  = 1'b0;
    commit_d = 1'b0;
    drop_d   = 1'b0;
    acc_inc  = 1'b0;
    filt_inc = 1'b0;
    runt_inc = 1'b0;
    rl_clear = 1'b0;
    rl_valid = 1'b0;
    rl_flush = 1'b0;
    rl_n     = rx_bus.bytes_valid;
    rl_data  = rx_bus.data;
    parse_et = 1'b0;
    cur      = state_q;
    // A new start aborts whatever is in flight and is decoded as HDR_0 this cycle.
    if (rx_bus.start) begin
      if (state_q inside {S_BODY, S_FLUSH}) begin
        drop_d   = 1'b1;
        rl_clear = 1'b1;
      end else if (state_q != S_IDLE) begin
        runt_inc = 1'b1;
      end
      cur     = S_HDR_0;
      state_d = S_HDR_0;
      hv_d    = 1'b0;
      vid_d   = '0;
      pcp_d   = '0;
    end
    hdr_abort = (cur inside {S_HDR_0, S_HDR_1, S_HDR_2, S_HDR_3, S_HDR_VLAN}) &&
                (rx_bus.commit || rx_bus.drop);
    if (hdr_abort) begin
      runt_inc = 1'b1;
      state_d  = S_IDLE;
    end else begin
      case (cur)
        S_IDLE: ;
        S_HDR_0: if (rx_bus.data_valid) begin
          dst_d[47:16] = rx_bus.data;
          state_d      = S_HDR_1;
        end
        S_HDR_1: if (rx_bus.data_valid) begin
          dst_d[15:0]  = rx_bus.data[31:16];
          src_d[47:32] = rx_bus.data[15:0];
          state_d      = S_HDR_2;
        end
        S_HDR_2: if (rx_bus.data_valid) begin
          src_d[31:0] = rx_bus.data;
          state_d     = S_HDR_3;
        end
        S_HDR_3: if (rx_bus.data_valid) begin
          if (VLAN_ENABLE && et == ETHERTYPE_VLAN) begin
            hv_d    = 1'b1;
            pcp_d   = rx_bus.data[15:13];
            vid_d   = rx_bus.data[11:0];
            state_d = S_HDR_VLAN;
          end else begin
            parse_et = 1'b1;
          end
        end
        S_HDR_VLAN: parse_et = rx_bus.data_valid;
        S_BODY: begin
          if (rx_bus.drop) begin
            rl_clear = 1'b1;
            drop_d   = 1'b1;
            state_d  = S_IDLE;
          end else if (rx_bus.commit) begin
            if (rl_cnt != 2'd0) begin
              rl_flush = 1'b1;
              state_d  = S_FLUSH;
            end else begin
              commit_d = 1'b1;
              acc_inc  = 1'b1;
              state_d  = S_IDLE;
            end
          end else begin
            rl_valid = rx_bus.data_valid;
          end
        end
        S_FLUSH: begin
          if (rx_bus.drop) begin
            drop_d   = 1'b1;
            rl_clear = 1'b1;
          end else begin
            commit_d = 1'b1;
            acc_inc  = 1'b1;
          end
          state_d = S_IDLE;
        end
        S_DISCARD: if (rx_bus.commit || rx_bus.drop) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // Ethertype word: filter decision, header publish, trailing two bytes seed the carry.
    if (parse_et) begin
      if (addr_ok && et >= ETHERTYPE_MIN) begin
        start_d  = 1'b1;
        hdr_d    = '{dst_q, src_q, et, hv_d, vid_d, pcp_d};
        rl_valid = 1'b1;
        rl_n     = 3'd2;
        rl_data  = {rx_bus.data[15:0], 16'h0000};
        state_d  = S_BODY;
      end else begin
        filt_inc = 1'b1;
        state_d  = S_DISCARD;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dst_q    <= '0;
      src_q    <= '0;
      hv_q     <= 1'b0;
      vid_q    <= '0;
      pcp_q    <= '0;
      hdr_q    <= '0;
      start_q  <= 1'b0;
      commit_q <= 1'b0;
      drop_q   <= 1'b0;
      acc_q    <= '0;
      filt_q   <= '0;
      runt_q   <= '0;
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      hv_q     <= hv_d;
      vid_q    <= vid_d;
      pcp_q    <= pcp_d;
      hdr_q    <= hdr_d;
      start_q  <= start_d;
      commit_q <= commit_d;
      drop_q   <= drop_d;
      acc_q    <= acc_q + {63'b0, acc_inc};
      filt_q   <= filt_q + {63'b0, filt_inc};
      runt_q   <= runt_q + {63'b0, runt_inc};
    end
  end

  ethernet_payload_realigner u_realign (
    .clk_i         (sys_clk),
    .rst_n_i       (rst_n),
    .clear_i       (rl_clear),
    .valid_i       (rl_valid),
    .n_i           (rl_n),
    .data_i        (rl_data),
    .flush_i       (rl_flush),
    .word_o        (rl_word),
    .bytes_valid_o (rl_bv),
    .valid_o       (rl_vld),
    .count_o       (rl_cnt)
  );

  always_comb begin
    l2_bus             = '0;
    l2_bus.start       = start_q;
    l2_bus.data_valid  = rl_vld;
    l2_bus.bytes_valid = rl_bv;
    l2_bus.data        = rl_word;
    l2_bus.commit      = commit_q;
    l2_bus.drop        = drop_q;
    l2_bus.dst_mac     = hdr_q.dst_mac;
    l2_bus.src_mac     = hdr_q.src_mac;
    l2_bus.ethertype   = hdr_q.ethertype;
    l2_bus.has_vlan    = hdr_q.has_vlan;
    l2_bus.vlan_id     = hdr_q.vlan_id;
    l2_bus.vlan_pcp    = hdr_q.vlan_pcp;
  end

  assign perf_rx_l2_accepted    = acc_q;
  assign perf_rx_l2_drop_filter = filt_q;
  assign perf_rx_l2_drop_runt   = runt_q;

endmodule

// File: tb/tb_ethernet_rx_l2_decoder.sv
// Directed bench for the L2 receive decoder: header parse, filter, realign, runt/drop paths.
module tb_ethernet_rx_l2_decoder;
  import ethernet_rx_l2_decoder_pkg::*;

  localparam logic [47:0] OUR  = 48'h123456789ABC;
  localparam logic [47:0] SRC1 = 48'hAABBCCDDEE01;
  localparam logic [47:0] SRC2 = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] SRC3 = 48'h665544332211;

  logic           sys_clk = 1'b0;
  logic           rst_n   = 1'b0;
  EthernetRxBus   rx;
  logic [47:0]    our_mac;
  logic           promisc;
  EthernetRxL2Bus l2;
  logic [63:0]    p_acc, p_filt, p_runt;

  always #5 sys_clk = ~sys_clk;

  ethernet_rx_l2_decoder dut (
    .sys_clk                (sys_clk),
    .rst_n                  (rst_n),
    .rx_bus                 (rx),
    .our_mac_address        (our_mac),
    .promisc_mode           (promisc),
    .l2_bus                 (l2),
    .perf_rx_l2_accepted    (p_acc),
    .perf_rx_l2_drop_filter (p_filt),
    .perf_rx_l2_drop_runt   (p_runt)
  );

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Output monitor: only this process writes these.
  logic [31:0]    wq[$];
  logic [2:0]     bq[$];
  int             n_start = 0, n_commit = 0, n_drop = 0, excl_err = 0;
  int             start_cyc = 0, commit_cyc = 0, drop_cyc = 0;
  EthernetRxL2Bus st_snap;
  always @(negedge sys_clk) if (rst_n) begin
    if (l2.data_valid) begin wq.push_back(l2.data); bq.push_back(l2.bytes_valid); end
    if (l2.start)  begin n_start++; start_cyc = cyc; st_snap = l2; end
    if (l2.commit) begin n_commit++; commit_cyc = cyc; end
    if (l2.drop)   begin n_drop++; drop_cyc = cyc; end
    if (int'(l2.commit) + int'(l2.drop) + int'(l2.data_valid) > 1 || (l2.start && l2.data_valid))
      excl_err++;
  end

  logic [7:0] frame [0:127];
  int f_cyc0, end_cyc, ws, s0, c0, d0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge sys_clk); #1; rx = '0; end
  endtask

  task automatic put_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et);
    for (int i = 0; i < 6; i++) begin
      frame[i]   = d[47-8*i -: 8];
      frame[6+i] = s[47-8*i -: 8];
    end
    frame[12] = et[15:8];
    frame[13] = et[7:0];
  endtask

  task automatic send_bytes(input int len);
    for (int i = 0; i < len; i += 4) begin
      @(posedge sys_clk); #1;
      rx = '0;
      rx.start       = (i == 0);
      rx.data_valid  = 1'b1;
      rx.bytes_valid = (len - i >= 4) ? 3'd4 : 3'(len - i);
      rx.data        = {frame[i], frame[i+1], frame[i+2], frame[i+3]};
      if (i == 0) f_cyc0 = cyc;
    end
  endtask

  task automatic send_end(input bit is_drop);
    @(posedge sys_clk); #1;
    rx = '0;
    rx.commit = !is_drop;
    rx.drop   = is_drop;
    end_cyc   = cyc;
  endtask

  task automatic mark();
    ws = wq.size(); s0 = n_start; c0 = n_commit; d0 = n_drop;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++; if (l2 !== '0) begin n_fail++; $display("FAIL rst_l2bus: got %h want 0", l2); end
    n_cmp++; if (p_acc !== 64'd0) begin n_fail++; $display("FAIL rst_acc: got %0d want 0", p_acc); end
    n_cmp++; if (p_filt !== 64'd0) begin n_fail++; $display("FAIL rst_filt: got %0d want 0", p_filt); end
    n_cmp++; if (p_runt !== 64'd0) begin n_fail++; $display("FAIL rst_runt: got %0d want 0", p_runt); end
    @(negedge sys_clk); rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_unicast();
    logic [31:0] e;
    mark();
    put_hdr(OUR, SRC1, 16'h0800);
    for (int i = 0; i < 46; i++) frame[14+i] = 8'(i);
    send_bytes(60); send_end(0); tick(4);
    n_cmp++; if (n_start - s0 != 1) begin n_fail++; $display("FAIL uc_starts: got %0d want 1", n_start - s0); end
    n_cmp++; if (start_cyc != f_cyc0 + 4) begin n_fail++; $display("FAIL uc_start_lat: got %0d want %0d", start_cyc, f_cyc0 + 4); end
    n_cmp++; if (st_snap.ethertype !== 16'h0800) begin n_fail++; $display("FAIL uc_et: got %h want 0800", st_snap.ethertype); end
    n_cmp++; if (st_snap.dst_mac !== OUR) begin n_fail++; $display("FAIL uc_dst: got %h want %h", st_snap.dst_mac, OUR); end
    n_cmp++; if (st_snap.src_mac !== SRC1) begin n_fail++; $display("FAIL uc_src: got %h want %h", st_snap.src_mac, SRC1); end
    n_cmp++; if (st_snap.has_vlan !== 1'b0) begin n_fail++; $display("FAIL uc_hasvlan: got %b want 0", st_snap.has_vlan); end
    n_cmp++; if (wq.size() - ws != 12) begin n_fail++; $display("FAIL uc_nwords: got %0d want 12", wq.size() - ws); end
    for (int k = 0; k < 11 && ws + k < wq.size(); k++) begin
      e = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      n_cmp++; if (wq[ws+k] !== e || bq[ws+k] !== 3'd4) begin n_fail++; $display("FAIL uc_word%0d: got %h/%0d want %h/4", k, wq[ws+k], bq[ws+k], e); end
    end
    if (wq.size() > ws + 11) begin
      n_cmp++; if (wq[ws+11] !== 32'h2C2D0000 || bq[ws+11] !== 3'd2) begin n_fail++; $display("FAIL uc_flush: got %h/%0d want 2c2d0000/2", wq[ws+11], bq[ws+11]); end
    end
    n_cmp++; if (n_commit - c0 != 1) begin n_fail++; $display("FAIL uc_commits: got %0d want 1", n_commit - c0); end
    n_cmp++; if (commit_cyc != end_cyc + 2) begin n_fail++; $display("FAIL uc_commit_lat: got %0d want %0d", commit_cyc, end_cyc + 2); end
    n_cmp++; if (p_acc !== 64'd1) begin n_fail++; $display("FAIL uc_acc: got %0d want 1", p_acc); end
  endtask

  task automatic test_vlan();
    mark();
    put_hdr(48'hFFFFFFFFFFFF, SRC2, 16'h8100);
    frame[14] = 8'hA0; frame[15] = 8'h64; frame[16] = 8'h86; frame[17] = 8'hDD;
    for (int i = 0; i < 5; i++) frame[18+i] = 8'h11 + 8'(i);
    send_bytes(23); send_end(0); tick(4);
    n_cmp++; if (start_cyc != f_cyc0 + 5) begin n_fail++; $display("FAIL vl_start_lat: got %0d want %0d", start_cyc, f_cyc0 + 5); end
    n_cmp++; if (st_snap.has_vlan !== 1'b1) begin n_fail++; $display("FAIL vl_hasvlan: got %b want 1", st_snap.has_vlan); end
    n_cmp++; if (st_snap.vlan_id !== 12'h064) begin n_fail++; $display("FAIL vl_id: got %h want 064", st_snap.vlan_id); end
    n_cmp++; if (st_snap.vlan_pcp !== 3'd5) begin n_fail++; $display("FAIL vl_pcp: got %0d want 5", st_snap.vlan_pcp); end
    n_cmp++; if (st_snap.ethertype !== 16'h86DD) begin n_fail++; $display("FAIL vl_et: got %h want 86dd", st_snap.ethertype); end
    n_cmp++; if (wq.size() - ws != 2) begin n_fail++; $display("FAIL vl_nwords: got %0d want 2", wq.size() - ws); end
    if (wq.size() >= ws + 2) begin
      n_cmp++; if (wq[ws] !== 32'h11121314 || bq[ws] !== 3'd4) begin n_fail++; $display("FAIL vl_w0: got %h/%0d want 11121314/4", wq[ws], bq[ws]); end
      n_cmp++; if (wq[ws+1] !== 32'h15000000 || bq[ws+1] !== 3'd1) begin n_fail++; $display("FAIL vl_w1: got %h/%0d want 15000000/1", wq[ws+1], bq[ws+1]); end
    end
    n_cmp++; if (commit_cyc != end_cyc + 2) begin n_fail++; $display("FAIL vl_commit_lat: got %0d want %0d", commit_cyc, end_cyc + 2); end
    n_cmp++; if (p_acc !== 64'd2) begin n_fail++; $display("FAIL vl_acc: got %0d want 2", p_acc); end
  endtask

  task automatic test_filter();
    for (int i = 0; i < 10; i++) frame[14+i] = 8'h30 + 8'(i);
    mark(); promisc = 1'b0;
    put_hdr(48'h020000000099, SRC1, 16'h0800);
    send_bytes(24); send_end(0); tick(3);
    n_cmp++; if (n_start != s0 || wq.size() != ws || n_commit != c0) begin n_fail++; $display("FAIL flt_outputs: got starts %0d words %0d commits %0d want none", n_start - s0, wq.size() - ws, n_commit - c0); end
    n_cmp++; if (p_filt !== 64'd1) begin n_fail++; $display("FAIL flt_cnt: got %0d want 1", p_filt); end
    mark(); promisc = 1'b1;
    send_bytes(24); send_end(0); tick(3);
    promisc = 1'b0;
    n_cmp++; if (n_start - s0 != 1 || p_acc !== 64'd3) begin n_fail++; $display("FAIL flt_promisc: got starts %0d acc %0d want 1/3", n_start - s0, p_acc); end
    mark();
    put_hdr(OUR, SRC1, 16'h05DC);
    send_bytes(24); send_end(0); tick(3);
    n_cmp++; if (n_start != s0 || p_filt !== 64'd2) begin n_fail++; $display("FAIL flt_len: got starts %0d filt %0d want 0/2", n_start - s0, p_filt); end
    mark();
    put_hdr(48'h01005E000001, SRC1, 16'h0800);
    send_bytes(24); send_end(0); tick(3);
    n_cmp++; if (n_start - s0 != 1 || p_acc !== 64'd4) begin n_fail++; $display("FAIL flt_mcast: got starts %0d acc %0d want 1/4", n_start - s0, p_acc); end
  endtask

  task automatic test_runt();
    mark();
    put_hdr(OUR, SRC1, 16'h0800);
    send_bytes(8); send_end(0); tick(3);
    n_cmp++; if (p_runt !== 64'd1) begin n_fail++; $display("FAIL rn_cnt: got %0d want 1", p_runt); end
    n_cmp++; if (n_start != s0 || wq.size() != ws || n_commit != c0) begin n_fail++; $display("FAIL rn_outputs: got starts %0d words %0d commits %0d want none", n_start - s0, wq.size() - ws, n_commit - c0); end
    mark();
    for (int i = 0; i < 8; i++) frame[14+i] = 8'h40 + 8'(i);
    send_bytes(22); send_end(0); tick(3);
    n_cmp++; if (wq.size() - ws != 2) begin n_fail++; $display("FAIL rn_nwords: got %0d want 2", wq.size() - ws); end
    if (wq.size() >= ws + 2) begin
      n_cmp++; if (wq[ws] !== 32'h40414243 || wq[ws+1] !== 32'h44454647 || bq[ws+1] !== 3'd4) begin n_fail++; $display("FAIL rn_words: got %h %h/%0d want 40414243 44454647/4", wq[ws], wq[ws+1], bq[ws+1]); end
    end
    n_cmp++; if (commit_cyc != end_cyc + 1) begin n_fail++; $display("FAIL rn_commit_lat: got %0d want %0d", commit_cyc, end_cyc + 1); end
    n_cmp++; if (p_acc !== 64'd5) begin n_fail++; $display("FAIL rn_acc: got %0d want 5", p_acc); end
  endtask

  task automatic test_drop();
    mark();
    put_hdr(OUR, SRC1, 16'h0800);
    for (int i = 0; i < 17; i++) frame[14+i] = 8'hE0 + 8'(i);
    send_bytes(31); send_end(1); tick(3);
    n_cmp++; if (n_drop - d0 != 1) begin n_fail++; $display("FAIL dr_pulses: got %0d want 1", n_drop - d0); end
    n_cmp++; if (drop_cyc != end_cyc + 1) begin n_fail++; $display("FAIL dr_lat: got %0d want %0d", drop_cyc, end_cyc + 1); end
    n_cmp++; if (n_commit != c0 || p_acc !== 64'd5) begin n_fail++; $display("FAIL dr_nocommit: got commits %0d acc %0d want 0/5", n_commit - c0, p_acc); end
  endtask

  task automatic test_back_to_back();
    mark();
    put_hdr(OUR, SRC1, 16'h0800);
    for (int i = 0; i < 8; i++) frame[14+i] = 8'h50 + 8'(i);
    send_bytes(22); send_end(0);
    put_hdr(OUR, SRC3, 16'h0806);
    for (int i = 0; i < 4; i++) frame[14+i] = 8'h60 + 8'(i);
    send_bytes(18); send_end(0); tick(4);
    n_cmp++; if (n_start - s0 != 2 || n_commit - c0 != 2) begin n_fail++; $display("FAIL bb_frames: got starts %0d commits %0d want 2/2", n_start - s0, n_commit - c0); end
    n_cmp++; if (wq.size() - ws != 3) begin n_fail++; $display("FAIL bb_nwords: got %0d want 3", wq.size() - ws); end
    if (wq.size() >= ws + 3) begin
      n_cmp++; if (wq[ws] !== 32'h50515253 || wq[ws+1] !== 32'h54555657 || wq[ws+2] !== 32'h60616263) begin n_fail++; $display("FAIL bb_words: got %h %h %h want 50515253 54555657 60616263", wq[ws], wq[ws+1], wq[ws+2]); end
    end
    n_cmp++; if (st_snap.src_mac !== SRC3 || st_snap.ethertype !== 16'h0806) begin n_fail++; $display("FAIL bb_hdr2: got %h/%h want %h/0806", st_snap.src_mac, st_snap.ethertype, SRC3); end
    n_cmp++; if (l2.src_mac !== SRC3 || l2.ethertype !== 16'h0806) begin n_fail++; $display("FAIL bb_hold: got %h/%h want %h/0806", l2.src_mac, l2.ethertype, SRC3); end
    n_cmp++; if (p_acc !== 64'd7) begin n_fail++; $display("FAIL bb_acc: got %0d want 7", p_acc); end
    n_cmp++; if (excl_err != 0) begin n_fail++; $display("FAIL strobe_excl: got %0d want 0", excl_err); end
  endtask

  task automatic test_reset_mid();
    put_hdr(OUR, SRC1, 16'h0800);
    for (int i = 0; i < 16; i++) frame[14+i] = 8'h90 + 8'(i);
    send_bytes(28);
    @(posedge sys_clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (l2 !== '0) begin n_fail++; $display("FAIL rm_l2bus: got %h want 0", l2); end
    n_cmp++; if (p_acc !== 64'd0 || p_filt !== 64'd0 || p_runt !== 64'd0) begin n_fail++; $display("FAIL rm_counters: got %0d/%0d/%0d want 0/0/0", p_acc, p_filt, p_runt); end
    rx = '0;
    tick(2);
    @(negedge sys_clk); rst_n = 1'b1;
    tick(1);
    mark();
    for (int i = 0; i < 8; i++) frame[14+i] = 8'h70 + 8'(i);
    send_bytes(22); send_end(0); tick(3);
    n_cmp++; if (n_start - s0 != 1 || p_acc !== 64'd1) begin n_fail++; $display("FAIL rm_after: got starts %0d acc %0d want 1/1", n_start - s0, p_acc); end
    if (wq.size() >= ws + 2) begin
      n_cmp++; if (wq[ws] !== 32'h70717273 || wq[ws+1] !== 32'h74757677) begin n_fail++; $display("FAIL rm_words: got %h %h want 70717273 74757677", wq[ws], wq[ws+1]); end
    end else begin
      n_cmp++; n_fail++; $display("FAIL rm_nwords: got %0d want 2", wq.size() - ws);
    end
  endtask

  initial begin
    rx = '0; our_mac = OUR; promisc = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 128; i++) frame[i] = 8'h00;
    test_reset();
    test_unicast();
    test_vlan();
    test_filter();
    test_runt();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
